ula_operand_sequencer: RTL and testbench

Sequential front/back-end for the combinational 8-bit signed ALU. It accepts operands and an opcode over a single narrow valid/ready input channel, A first and then B. It holds them stable on the ALU operand ports, captures the ALU result and overflow flag one cycle later, and presents them on a valid/ready output channel. It also keeps a saturating count of overflow events for software/debug.

---
 rtl/ula_pkg.sv | 27 ++
 rtl/ula_operand_sequencer_sat_counter.sv | 24 ++
 rtl/ula_operand_sequencer.sv | 123 ++++++++++++
 tb/tb_ula_operand_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Opcode encoding, FSM states and counter width.
package ula_pkg;

    localparam int BITS      = 8;
    localparam int OVF_CNT_W = 8;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GET_B = 2'b01,
        S_EXEC  = 2'b10,
        S_HOLD  = 2'b11
    } state_e;

    // Only ADD/SUB can raise a meaningful overflow flag.
    function automatic logic is_arith(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/ula_operand_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over a same-cycle increment; never wraps.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count up to all-ones and stick there until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ula_operand_sequencer.sv
// Two-beat operand collector and result holder for the 8-bit ALU.
// Keeps ALU operands stable and counts overflow events.
module ula_operand_sequencer
    import ula_pkg::*;
#(
    parameter int BITS_P = ula_pkg::BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITS_P-1:0]    in_data,
    input  logic [1:0]           in_op,
    output logic [BITS_P-1:0]    op_a,
    output logic [BITS_P-1:0]    op_b,
    output logic [1:0]           op_f,
    input  logic [BITS_P-1:0]    alu_result,
    input  logic                 alu_ovf,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BITS_P-1:0]    res_data,
    output logic                 res_ovf,
    output logic [OVF_CNT_W-1:0] ovf_count,
    input  logic                 cnt_clr,
    output logic                 busy
);

    state_e state;
    state_e state_nx;
    logic   load_a;
    logic   load_b;
    logic   capture;
    logic   ovf_hit;

    // State register; reset aborts any partial operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake outputs decoded from state.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        load_a    = 1'b0;
        load_b    = 1'b0;
        capture   = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load_a   = 1'b1;
                    state_nx = S_GET_B;
                end
            end
            S_GET_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_b   = 1'b1;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                capture  = 1'b1;
                state_nx = S_HOLD;
            end
            S_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand registers change only on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
            op_f <= 2'b00;
        end else begin
            if (load_a) begin
                op_a <= in_data;
                op_f <= in_op;
            end
            if (load_b) begin
                op_b <= in_data;
            end
        end
    end

    assign ovf_hit = alu_ovf && is_arith(op_f);

    // Result capture at the end of EXEC, held through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_ovf  <= 1'b0;
        end else if (capture) begin
            res_data <= alu_result;
            res_ovf  <= ovf_hit;
        end
    end

    sat_counter #(
        .W(OVF_CNT_W)
    ) u_ovf_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (capture && ovf_hit),
        .clr  (cnt_clr),
        .count(ovf_count)
    );

endmodule

// File: tb/tb_ula_operand_sequencer.sv
// Directed bench for ula_operand_sequencer.
// Includes a behavioural 8-bit signed ALU on the operand ports.
module tb_ula_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_op;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] op_f;
    logic [7:0] alu_result;
    logic       alu_ovf;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_ovf;
    logic [7:0] ovf_count;
    logic       cnt_clr;
    logic       busy;

    int checks;
    int failures;

    ula_operand_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_f      (op_f),
        .alu_result(alu_result),
        .alu_ovf   (alu_ovf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .ovf_count (ovf_count),
        .cnt_clr   (cnt_clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model; logic ops raise a junk overflow flag that must be masked.
    always_comb begin
        alu_result = 8'h00;
        alu_ovf    = 1'b0;
        case (op_f)
            2'b00: begin
                alu_result = op_a & op_b;
                alu_ovf    = 1'b1;
            end
            2'b01: begin
                alu_result = op_a | op_b;
                alu_ovf    = 1'b1;
            end
            2'b10: begin
                alu_result = op_a + op_b;
                alu_ovf    = (op_a[7] == op_b[7]) && (alu_result[7] != op_a[7]);
            end
            default: begin
                alu_result = op_a - op_b;
                alu_ovf    = (op_a[7] != op_b[7]) && (alu_result[7] != op_a[7]);
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present A then B back-to-back; returns at the negedge inside EXEC.
    task automatic send_ab(input logic [7:0] a, input logic [1:0] op,
                           input logic [7:0] b, input logic [1:0] op_b_beat);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = a;
        in_op    = op;
        @(negedge clk);
        in_data  = b;
        in_op    = op_b_beat;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_op    = 2'b00;
    endtask

    // Full operation with res_ready high; returns at negedge after HOLD.
    task automatic run_op(input logic [7:0] a, input logic [1:0] op, input logic [7:0] b);
        send_ab(a, op, b, op);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_op     = 2'b00;
        res_ready = 1'b1;
        cnt_clr   = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_cnt", ovf_count, 0);
        rst_n = 1'b1;

        // AND, back-to-back beats
        send_ab(8'h0F, 2'b00, 8'h3C, 2'b00);
        chk("and_exec_valid", res_valid, 0);
        chk("and_exec_ready", in_ready, 0);
        chk("and_exec_busy", busy, 1);
        @(negedge clk);
        chk("and_valid", res_valid, 1);
        chk("and_data", res_data, 8'h0C);
        chk("and_ovf", res_ovf, 0);
        @(negedge clk);
        chk("and_valid_1cyc", res_valid, 0);
        chk("and_idle_ready", in_ready, 1);
        chk("and_cnt", ovf_count, 0);

        // ADD overflow
        run_op(8'h64, 2'b10, 8'h32);
        chk("add_data", res_data, 8'h96);
        chk("add_ovf", res_ovf, 1);
        chk("add_cnt", ovf_count, 1);

        // SUB underflow with backpressure and a refused beat
        res_ready = 1'b0;
        send_ab(8'h80, 2'b11, 8'h01, 2'b11);
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_op    = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sub_valid", res_valid, 1);
            chk("sub_data", res_data, 8'h7F);
            chk("sub_ovf", res_ovf, 1);
            chk("sub_in_ready", in_ready, 0);
            chk("sub_op_a", op_a, 8'h80);
            chk("sub_op_b", op_b, 8'h01);
            chk("sub_op_f", op_f, 2'b11);
        end
        in_valid  = 1'b0;
        in_data   = 8'h00;
        res_ready = 1'b1;
        @(negedge clk);
        chk("sub_release", res_valid, 0);
        chk("sub_busy", busy, 0);
        chk("sub_cnt", ovf_count, 2);

        // Opcode sampled on beat 1 only
        send_ab(8'hA0, 2'b01, 8'h05, 2'b10);
        @(negedge clk);
        chk("opc_data", res_data, 8'hA5);
        chk("opc_ovf", res_ovf, 0);
        chk("opc_op_f", op_f, 2'b01);
        @(negedge clk);
        chk("opc_cnt", ovf_count, 2);

        // Saturation: 260 overflowing adds on top of count 2
        for (int i = 0; i < 260; i++) begin
            run_op(8'h7F, 2'b10, 8'h01);
        end
        chk("sat_data", res_data, 8'h80);
        chk("sat_cnt", ovf_count, 255);

        // Clear wins over a same-cycle increment
        send_ab(8'h7F, 2'b10, 8'h01, 2'b10);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_ovf", res_ovf, 1);
        chk("clr_cnt", ovf_count, 0);
        @(negedge clk);

        // Reset in GET_B, with a B beat presented during reset
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_op    = 2'b10;
        @(negedge clk);
        chk("mid_getb_busy", busy, 1);
        in_data = 8'h77;
        rst_n   = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_op_a", op_a, 0);
        chk("mid_op_f", op_f, 0);
        chk("mid_res_data", res_data, 0);
        chk("mid_res_valid", res_valid, 0);
        chk("mid_in_ready", in_ready, 1);
        @(negedge clk);
        chk("mid_op_b", op_b, 0);
        chk("mid_busy2", busy, 0);
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_op    = 2'b00;
        rst_n    = 1'b1;

        run_op(8'h01, 2'b10, 8'h02);
        chk("post_data", res_data, 8'h03);
        chk("post_ovf", res_ovf, 0);
        chk("post_op_a", op_a, 8'h01);
        chk("post_op_b", op_b, 8'h02);
        chk("post_cnt", ovf_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
